// File: rtl/q1_share_arbiter.sv
// Round-robin owner of the shared capture bit q1 between requesters A and B.
// Each grant lasts at most MAX_HOLD capture cycles, with direct hand-off to a waiting peer.
module q1_share_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a,
    input  logic          b,
    input  logic          fa,
    input  logic          fb,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          busy,
    output logic          q1,
    output logic          upd,
    output logic [CW-1:0] grant_cnt
);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t        state;
    state_t        nxt;
    state_t        oth_st;
    logic          last;      // 1: B was served most recently
    logic [CW-1:0] hold_cnt;
    logic          own_req;
    logic          oth_req;
    logic          own_dat;
    logic          capture;
    logic          expire;
    logic          done;
    logic          enter;

    // The current owner's view is folded into own/oth signals so both grant states share one path.
    always_comb begin
        own_req = (state == GNT_B) ? fb : fa;
        oth_req = (state == GNT_B) ? fa : fb;
        own_dat = (state == GNT_B) ? b  : a;
        oth_st  = (state == GNT_B) ? GNT_A : GNT_B;
        capture = (state != IDLE) && own_req;
        expire  = capture && (hold_cnt == HOLD_LAST);
        done    = (state != IDLE) && (!own_req || expire);
        nxt     = state;
        enter   = 1'b0;
        case (state)
            IDLE: begin
                if (fa && fb) begin
                    nxt   = last ? GNT_A : GNT_B;
                    enter = 1'b1;
                end else if (fa) begin
                    nxt   = GNT_A;
                    enter = 1'b1;
                end else if (fb) begin
                    nxt   = GNT_B;
                    enter = 1'b1;
                end
            end
            default: begin
                if (done) begin
                    if (oth_req) begin
                        nxt   = oth_st;
                        enter = 1'b1;
                    end else if (own_req) begin
                        nxt   = state;
                        enter = 1'b1;
                    end else begin
                        nxt   = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            hold_cnt  <= '0;
            grant_cnt <= '0;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            busy      <= 1'b0;
            q1        <= 1'b0;
            upd       <= 1'b0;
        end else begin
            state     <= nxt;
            gnt_a     <= (nxt == GNT_A);
            gnt_b     <= (nxt == GNT_B);
            busy      <= (nxt != IDLE);
            upd       <= capture;
            grant_cnt <= grant_cnt + CW'(enter);
            if (capture)
                q1 <= own_dat;
            if (done)
                last <= (state == GNT_B);
            if (enter)
                hold_cnt <= '0;
            else if (capture)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_q1_share_arbiter.sv
// Directed bench for q1_share_arbiter: reset, single requester, tie rotation,
// early release, asynchronous mid-grant reset and grant counter wrap.
module tb_q1_share_arbiter;

    logic       clk = 1'b0;
    logic       rst, a, b, fa, fb;
    logic       gnt_a, gnt_b, busy, q1, upd;
    logic [7:0] grant_cnt;

    logic       rst2, fa2;
    logic       gnt_a2, gnt_b2, busy2, q12, upd2;
    logic [3:0] grant_cnt2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    q1_share_arbiter #(.MAX_HOLD(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .fa(fa), .fb(fb),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy), .q1(q1), .upd(upd),
        .grant_cnt(grant_cnt)
    );

    q1_share_arbiter #(.MAX_HOLD(1), .CW(4)) dut_wrap (
        .clk(clk), .rst(rst2), .a(1'b1), .b(1'b0), .fa(fa2), .fb(1'b0),
        .gnt_a(gnt_a2), .gnt_b(gnt_b2), .busy(busy2), .q1(q12), .upd(upd2),
        .grant_cnt(grant_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Holds reset for two edges with the given inputs, releasing 1 time unit after the second edge.
    task automatic do_reset(input logic ia, input logic ib, input logic ifa, input logic ifb);
        a = ia; b = ib; fa = ifa; fb = ifb;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst2 = 1'b1;
        fa2  = 1'b0;

        // Reset, then idle
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_gnt_a", 32'(gnt_a), 0);
        check("rst_gnt_b", 32'(gnt_b), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_q1", 32'(q1), 0);
        check("rst_upd", 32'(upd), 0);
        check("rst_cnt", 32'(grant_cnt), 0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("idle_q1", 32'(q1), 0);
            check("idle_cnt", 32'(grant_cnt), 0);
            check("idle_busy", 32'(busy), 0);
        end

        // Single requester A, a toggling; capture edge k samples a = k%2
        do_reset(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            check("single_gnt_a", 32'(gnt_a), 1);
            check("single_gnt_b", 32'(gnt_b), 0);
            check("single_cnt", 32'(grant_cnt), 32'(1 + (k - 1) / 4));
            check("single_upd", 32'(upd), (k >= 2) ? 1 : 0);
            if (k >= 2)
                check("single_q1", 32'(q1), 32'(k % 2));
            a = 1'((k + 1) % 2);
        end

        // Tie from reset: A first, then strict 4/4 alternation
        do_reset(1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            check("tie_gnt_a", 32'(gnt_a), (((k - 1) / 4) % 2 == 0) ? 1 : 0);
            check("tie_one_hot", 32'(gnt_a) + 32'(gnt_b), 1);
            check("tie_busy", 32'(busy), 1);
            check("tie_cnt", 32'(grant_cnt), 32'(1 + (k - 1) / 4));
            if (k >= 2)
                check("tie_q1", 32'(q1), (((k - 2) / 4) % 2 == 0) ? 1 : 0);
        end

        // Early release: fa high for two captures, then drop hands off to B
        do_reset(1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("early_gnt_a", 32'(gnt_a), 1);
        @(posedge clk); #1;
        check("early_cap1", 32'(upd), 1);
        @(posedge clk); #1;
        check("early_cap2", 32'(upd), 1);
        check("early_still_a", 32'(gnt_a), 1);
        fa = 1'b0;
        @(posedge clk); #1;
        check("early_gnt_b", 32'(gnt_b), 1);
        check("early_gnt_a_off", 32'(gnt_a), 0);
        check("early_upd", 32'(upd), 0);
        check("early_q1", 32'(q1), 1);
        check("early_cnt", 32'(grant_cnt), 2);
        check("early_last", 32'(dut.last), 0);

        // Mid-grant asynchronous reset during GNT_B with q1 = 1
        do_reset(1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("mid_gnt_b", 32'(gnt_b), 1);
        @(posedge clk); #1;
        check("mid_q1_set", 32'(q1), 1);
        #3 rst = 1'b1;
        #1;
        check("mid_gnt_b_off", 32'(gnt_b), 0);
        check("mid_q1_clr", 32'(q1), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_cnt", 32'(grant_cnt), 0);
        fa = 1'b1; fb = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("mid_tie_a", 32'(gnt_a), 1);
        check("mid_tie_b", 32'(gnt_b), 0);
        check("mid_tie_cnt", 32'(grant_cnt), 1);

        // Grant counter wrap with CW = 4, MAX_HOLD = 1
        @(posedge clk); #1;
        rst2 = 1'b0;
        fa2  = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            check("wrap_gnt_a", 32'(gnt_a2), 1);
            if (k >= 15)
                check("wrap_cnt", 32'(grant_cnt2), 32'(k % 16));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
